// File: rtl/battle_pkg.sv
// Shared coordinate type, box FSM states and screen limits for the battle box.
package battle_pkg;
  typedef logic [9:0] coord_t;
  typedef enum logic [1:0] {IDLE, MOVE, DONE} state_t;
  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;
endpackage

// File: rtl/box_edge_stepper.sv
// One box edge: moves toward its target by at most STEP when enabled.
// Purely combinational; the caller owns the edge register.
module box_edge_stepper
  import battle_pkg::*;
#(
  parameter int STEP = 4
) (
  input  coord_t cur,
  input  coord_t tgt,
  input  logic   en,
  output coord_t nxt,
  output logic   at_target
);
  localparam coord_t STEP_C = coord_t'(STEP);

  logic   up;
  coord_t diff;
  coord_t amt;

  always_comb begin
    up   = tgt > cur;
    diff = up ? (tgt - cur) : (cur - tgt);
    amt  = (diff > STEP_C) ? STEP_C : diff;
    nxt  = cur;
    if (en) nxt = up ? (cur + amt) : (cur - amt);
  end

  assign at_target = (cur == tgt);
endmodule

// File: rtl/battle_box_border.sv
// Animated battle box: accepts target boxes, glides edges per frame_tick,
// and flags border / inside pixels one Pclk after the scan position.
module battle_box_border
  import battle_pkg::*;
#(
  parameter int THICK = 5,
  parameter int STEP  = 4,
  parameter int RST_L = 196,
  parameter int RST_T = 196,
  parameter int RST_R = 444,
  parameter int RST_B = 444
) (
  input  logic       Pclk,
  input  logic       rst_n,
  input  logic [9:0] xx,
  input  logic [9:0] yy,
  input  logic       aactive,
  input  logic       frame_tick,
  input  logic       tgt_valid,
  input  logic [9:0] tgt_left,
  input  logic [9:0] tgt_top,
  input  logic [9:0] tgt_right,
  input  logic [9:0] tgt_bottom,
  output logic       tgt_ready,
  output logic       BorderOn,
  output logic       InsideOn,
  output logic       busy,
  output logic       done,
  output logic       err
);
  localparam logic [10:0] TH  = 11'(THICK);
  localparam logic [10:0] TH2 = 11'(2 * THICK);

  state_t state;
  coord_t bl, bt, br, bb;
  coord_t gl, gt, gr, gb;
  coord_t nl, nt, nr, nb;
  logic   al, at, ar, ab;
  logic   step_en, all_at, tgt_ok, tgt_same;

  assign step_en = (state == MOVE) && frame_tick;
  assign all_at  = al && at && ar && ab;

  box_edge_stepper #(.STEP(STEP)) u_left   (.cur(bl), .tgt(gl), .en(step_en), .nxt(nl), .at_target(al));
  box_edge_stepper #(.STEP(STEP)) u_top    (.cur(bt), .tgt(gt), .en(step_en), .nxt(nt), .at_target(at));
  box_edge_stepper #(.STEP(STEP)) u_right  (.cur(br), .tgt(gr), .en(step_en), .nxt(nr), .at_target(ar));
  box_edge_stepper #(.STEP(STEP)) u_bottom (.cur(bb), .tgt(gb), .en(step_en), .nxt(nb), .at_target(ab));

  // Widened to 11 bits so left+2*THICK cannot wrap past 1023.
  assign tgt_ok = ({1'b0, tgt_left} + TH2 < {1'b0, tgt_right})
               && ({1'b0, tgt_top} + TH2 < {1'b0, tgt_bottom})
               && ({1'b0, tgt_right} <= 11'(SCREEN_W))
               && ({1'b0, tgt_bottom} <= 11'(SCREEN_H));
  assign tgt_same = (tgt_left == bl) && (tgt_top == bt)
                 && (tgt_right == br) && (tgt_bottom == bb);

  always_ff @(posedge Pclk) begin
    if (!rst_n) begin
      state     <= IDLE;
      bl <= coord_t'(RST_L); bt <= coord_t'(RST_T);
      br <= coord_t'(RST_R); bb <= coord_t'(RST_B);
      gl <= coord_t'(RST_L); gt <= coord_t'(RST_T);
      gr <= coord_t'(RST_R); gb <= coord_t'(RST_B);
      tgt_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (tgt_valid && tgt_ready) begin
            if (!tgt_ok) begin
              err <= 1'b1;
            end else begin
              gl <= tgt_left;  gt <= tgt_top;
              gr <= tgt_right; gb <= tgt_bottom;
              tgt_ready <= 1'b0;
              if (tgt_same) begin
                state <= DONE;
              end else begin
                state <= MOVE;
                busy  <= 1'b1;
              end
            end
          end
        end
        MOVE: begin
          if (all_at) begin
            state <= DONE;
            busy  <= 1'b0;
          end else if (step_en) begin
            bl <= nl; bt <= nt; br <= nr; bb <= nb;
          end
        end
        DONE: begin
          done      <= 1'b1;
          tgt_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [10:0] x11, y11;
  logic        outer, inner;

  // Inner upper bounds use xx+THICK < R rather than R-THICK to avoid underflow.
  always_comb begin
    x11   = {1'b0, xx};
    y11   = {1'b0, yy};
    outer = (xx >= bl) && (xx < br) && (yy >= bt) && (yy < bb);
    inner = (x11 >= {1'b0, bl} + TH) && (x11 + TH < {1'b0, br})
         && (y11 >= {1'b0, bt} + TH) && (y11 + TH < {1'b0, bb});
  end

  always_ff @(posedge Pclk) begin
    if (!rst_n) begin
      BorderOn <= 1'b0;
      InsideOn <= 1'b0;
    end else begin
      BorderOn <= aactive && outer && !inner;
      InsideOn <= aactive && inner;
    end
  end
endmodule
